shreg164_loader: RTL and testbench



---
 rtl/shreg164_pkg.sv | 18 +
 rtl/shreg164_rr_arb2.sv | 37 +++
 rtl/shreg164_loader.sv | 149 ++++++++++++++
 tb/tb_shreg164_loader.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shreg164_pkg.sv
// shreg164_pkg: shared types and constants for the '164 chain loader.
package shreg164_pkg;

  // Each 74AC164 device holds one byte.
  localparam int BITS_PER_DEV = 8;

  // Longest chain the loader is meant to drive.
  localparam int MAX_CHAIN = 4;

  // Loader FSM states; exported on the loader's dbg_state port.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/shreg164_rr_arb2.sv
// shreg164_rr_arb2: two-way round-robin arbiter. A lone valid requester wins.
// On a tie the requester that did not own the previous transfer wins.
module shreg164_rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_owner,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

  // Pick the winner; no grant at all while disabled.
  always_comb begin
    gnt     = 2'b00;
    gnt_idx = last_owner;
    if (en) begin
      case (valid)
        2'b01: begin
          gnt     = 2'b01;
          gnt_idx = 1'b0;
        end
        2'b10: begin
          gnt     = 2'b10;
          gnt_idx = 1'b1;
        end
        2'b11: begin
          gnt_idx = ~last_owner;
          gnt     = last_owner ? 2'b01 : 2'b10;
        end
        default: begin
          gnt     = 2'b00;
          gnt_idx = last_owner;
        end
      endcase
    end
  end

endmodule

// File: rtl/shreg164_loader.sv
// shreg164_loader: shares a chain of '164-style SIPO shift registers between
// two requesters. It accepts a word from the round-robin winner, optionally
// clears the chain, then shifts the word MSB-first with a shift-enable strobe.
// Optional feature: define SHREG_CLR_EN to pulse MRn low for CLR_CYCLES
// cycles after every accept. Without it MRn is tied high.
//
// Handshake: reqN_ready is combinational and high only for the arbitration
// winner while the FSM is IDLE and R is low. A word transfers on the rising
// edge where reqN_valid && reqN_ready. The word is copied locally, so the
// requester may change reqN_data right after that edge. reqN_valid is ignored
// while a transfer is in progress.
module shreg164_loader
  import shreg164_pkg::*;
#(
  parameter int CHAIN      = 1,
  parameter int CLR_CYCLES = 1
) (
  input  logic                          C,
  input  logic                          R,
  input  logic                          req0_valid,
  input  logic [BITS_PER_DEV*CHAIN-1:0] req0_data,
  output logic                          req0_ready,
  input  logic                          req1_valid,
  input  logic [BITS_PER_DEV*CHAIN-1:0] req1_data,
  output logic                          req1_ready,
  output logic                          DS,
  output logic                          SE,
  output logic                          MRn,
  output logic                          busy,
  output logic                          owner,
  output logic                          done,
  output state_t                        dbg_state
);

  localparam int W  = BITS_PER_DEV * CHAIN;
  localparam int CW = $clog2(W) + 1;

  state_t          state;
  logic [W-1:0]    sbuf;
  logic [CW-1:0]   cnt;
  logic            ds_q;
  logic            se_q;
  logic            done_q;
  logic            busy_q;
  logic            owner_q;
  logic [1:0]      gnt;
  logic            gnt_idx;
  logic [W-1:0]    acc_word;
`ifdef SHREG_CLR_EN
  logic            mrn_q;
  logic [3:0]      clr_cnt;
`endif

  shreg164_rr_arb2 u_arb (
    .valid      ({req1_valid, req0_valid}),
    .last_owner (owner_q),
    .en         ((state == IDLE) && !R),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign acc_word   = gnt_idx ? req1_data : req0_data;

  assign DS        = ds_q;
  assign SE        = se_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign owner     = owner_q;
  assign dbg_state = state;
`ifdef SHREG_CLR_EN
  assign MRn = mrn_q;
`else
  assign MRn = 1'b1;
`endif

  // Transfer sequencer: accept, optional clear, W shift cycles, done pulse.
  // sbuf shifts left so bit W-1 always holds the next bit to present on DS.
  always_ff @(posedge C) begin
    if (R) begin
      state   <= IDLE;
      ds_q    <= 1'b0;
      se_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      owner_q <= 1'b1;
      sbuf    <= '0;
      cnt     <= '0;
`ifdef SHREG_CLR_EN
      mrn_q   <= 1'b1;
      clr_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|gnt) begin
            owner_q <= gnt_idx;
            busy_q  <= 1'b1;
            cnt     <= '0;
`ifdef SHREG_CLR_EN
            sbuf    <= acc_word;
            mrn_q   <= 1'b0;
            clr_cnt <= '0;
            state   <= CLEAR;
`else
            sbuf    <= acc_word << 1;
            ds_q    <= acc_word[W-1];
            se_q    <= 1'b1;
            state   <= SHIFT;
`endif
          end
        end
`ifdef SHREG_CLR_EN
        CLEAR: begin
          if (clr_cnt == 4'(CLR_CYCLES - 1)) begin
            mrn_q <= 1'b1;
            se_q  <= 1'b1;
            ds_q  <= sbuf[W-1];
            sbuf  <= sbuf << 1;
            state <= SHIFT;
          end else begin
            clr_cnt <= clr_cnt + 4'd1;
          end
        end
`endif
        SHIFT: begin
          if (cnt == CW'(W - 1)) begin
            se_q   <= 1'b0;
            ds_q   <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            cnt  <= cnt + 1'b1;
            ds_q <= sbuf[W-1];
            sbuf <= sbuf << 1;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shreg164_loader.sv
// tb_shreg164_loader: randomized and directed bench for shreg164_loader.
// The reference is a timeline model: after an accept, a transfer is a fixed
// sequence of clear, shift and done cycles counted by its age in cycles.
// A behavioural '164 chain built from DS/SE/MRn is read at every done pulse.
module tb_shreg164_loader;
  import shreg164_pkg::*;

  localparam int CHAIN      = 2;
  localparam int CLR_CYCLES = 2;
  localparam int W          = 8 * CHAIN;
`ifdef SHREG_CLR_EN
  localparam int CLRC = CLR_CYCLES;
`else
  localparam int CLRC = 0;
`endif
  localparam int LAST_AGE = CLRC + W + 1;

  // ---------------- clock / reset ----------------
  logic         C = 1'b0;
  logic         R = 1'b1;
  logic         req0_valid = 1'b0;
  logic [W-1:0] req0_data  = '0;
  logic         req1_valid = 1'b0;
  logic [W-1:0] req1_data  = '0;
  logic         req0_ready, req1_ready;
  logic         DS, SE, MRn, busy, owner, done;
  state_t       dbg_state;

  always #5 C = ~C;

  shreg164_loader #(.CHAIN(CHAIN), .CLR_CYCLES(CLR_CYCLES)) dut (
    .C          (C),
    .R          (R),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .DS         (DS),
    .SE         (SE),
    .MRn        (MRn),
    .busy       (busy),
    .owner      (owner),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int           n_chk  = 0;
  int           n_pass = 0;
  bit           chk_en = 0;
  logic [W:0]   exp_q[$];        // {owner, word} per accepted transfer
  int           owner_log[$];    // owner seen at each done pulse
  int           age     = 0;     // 0 = idle, else cycles since accept
  logic         m_owner = 1'b1;
  logic [W-1:0] m_word  = '0;
  int           n_acc   = 0;
  logic [W-1:0] chain_q = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
  endtask

  // Reference model: check this cycle's outputs, then advance to next edge.
  always @(negedge C) begin
    logic e0, e1;
    bit   shifting;
    e0 = 1'b0;
    e1 = 1'b0;
    if (!R && age == 0) begin
      if (req0_valid && req1_valid) begin
        e0 = m_owner;
        e1 = !m_owner;
      end else begin
        e0 = req0_valid;
        e1 = req1_valid;
      end
    end
    shifting = (age >= CLRC + 1) && (age <= CLRC + W);
    if (chk_en) begin
      chk("req0_ready", req0_ready, e0);
      chk("req1_ready", req1_ready, e1);
      chk("busy", busy, age != 0);
      chk("idle_state", dbg_state == IDLE, age == 0);
      chk("se", SE, shifting);
      chk("mrn", MRn, !(age >= 1 && age <= CLRC));
      chk("done", done, age == LAST_AGE);
      chk("owner", owner, m_owner);
      if (shifting) chk("ds", DS, m_word[W + CLRC - age]);
    end
    if (R) begin
      age     = 0;
      m_owner = 1'b1;
      exp_q.delete();
    end else if (age != 0) begin
      age = (age == LAST_AGE) ? 0 : age + 1;
    end else if (e0 && req0_valid) begin
      age = 1; m_owner = 1'b0; m_word = req0_data; n_acc++;
      exp_q.push_back({1'b0, req0_data});
    end else if (e1 && req1_valid) begin
      age = 1; m_owner = 1'b1; m_word = req1_data; n_acc++;
      exp_q.push_back({1'b1, req1_data});
    end
  end

  // Monitor: at each done pulse the chain must hold the accepted word.
  always @(negedge C) begin
    logic [W:0] e;
    if (chk_en && done) begin
      owner_log.push_back(int'(owner));
      if (exp_q.size() == 0) begin
        chk("done_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("chain_word", chain_q, e[W-1:0]);
        chk("done_owner", owner, e[W]);
      end
    end
    if (!MRn) chain_q = '0;
    else if (SE) chain_q = {chain_q[W-2:0], DS};
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int p, input logic [W-1:0] d, input logic [W-1:0] after);
    bit got;
    got = 0;
    @(posedge C); #1;
    if (p == 0) begin req0_data = d; req0_valid = 1'b1; end
    else        begin req1_data = d; req1_valid = 1'b1; end
    for (int t = 0; t < 400 && !got; t++) begin
      @(negedge C);
      if ((p == 0) ? req0_ready : req1_ready) got = 1;
    end
    @(posedge C); #1;
    if (p == 0) begin req0_valid = 1'b0; req0_data = after; end
    else        begin req1_valid = 1'b0; req1_data = after; end
    if (!got) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int t = 0; t < 400 && !ok; t++) begin
      @(negedge C);
      if (age == 0) ok = 1;
    end
    if (!ok) chk("idle_timeout", 32'd0, 32'd1);
    @(posedge C); #1;
  endtask

  task automatic do_reset(input int cycles);
    @(posedge C); #1;
    R = 1'b1;
    repeat (cycles) @(posedge C);
    #1 R = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    @(posedge C); #1;
    chk_en = 1;
    repeat (2) @(posedge C);
    #1 R = 1'b0;

    // Single words from each side.
    send(0, 16'h00A5, 16'h0000);
    wait_idle();
    send(1, 16'h1234, 16'h0000);
    wait_idle();

    // Both held valid from reset: grants must alternate 0,1,0.
    do_reset(2);
    owner_log.delete();
    req0_data = 16'h0011; req1_data = 16'h0022;
    req0_valid = 1'b1; req1_valid = 1'b1;
    begin
      int target;
      target = n_acc + 3;
      for (int t = 0; t < 400 && n_acc < target; t++) @(negedge C);
    end
    @(posedge C); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle();
    chk("rr_count", owner_log.size(), 3);
    if (owner_log.size() >= 3) begin
      chk("rr_first", owner_log[0], 0);
      chk("rr_second", owner_log[1], 1);
      chk("rr_third", owner_log[2], 0);
    end

    // Requester data changes right after accept.
    send(0, 16'h003C, 16'h00FF);
    wait_idle();

    // Reset in the middle of the shift, then a clean word.
    send(0, 16'hBEEF, 16'h0000);
    repeat (CLRC + 4) @(posedge C);
    #1 R = 1'b1;
    @(posedge C); #1 R = 1'b0;
    send(0, 16'h0081, 16'h0000);
    wait_idle();

    // req1 arrives during a req0 transfer and must wait for IDLE.
    fork
      send(0, 16'hC0DE, 16'h0000);
      begin
        repeat (3) @(posedge C);
        send(1, 16'h5A5A, 16'h0000);
      end
    join
    wait_idle();

    // Random traffic from both sides.
    fork
      for (int i = 0; i < 12; i++) begin
        repeat ($urandom_range(0, 5)) @(posedge C);
        send(0, W'($urandom), W'($urandom));
      end
      for (int i = 0; i < 12; i++) begin
        repeat ($urandom_range(0, 5)) @(posedge C);
        send(1, W'($urandom), W'($urandom));
      end
    join
    wait_idle();
    repeat (3) @(posedge C);
    chk("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
